// File: rtl/lif_neuron_array.sv
// lif_neuron_array
// ----------------
// Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons that
// share one update datapath. Membrane potentials and refractory counters live
// in internal register arrays. Each accepted current beat updates the neuron
// at the running index, which then advances and wraps at NUM_NEURONS-1.
//
// Optional feature macro: LIF_STATS_EN. When it is defined, a per-frame spike
// counter is kept and published on spike_count at every frame_done.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset, clears all neuron state
//   cur_valid    in   current beat valid
//   cur_ready    out  array accepts a beat (low only while a spike is held)
//   cur_data     in   input current for the neuron at the current index
//   spike_valid  out  spike event pending
//   spike_ready  in   downstream accepts the spike
//   spike_id     out  index of the spiking neuron
//   frame_done   out  one-cycle pulse after neuron NUM_NEURONS-1 is updated
//   spike_count  out  spikes in the last frame (LIF_STATS_EN only)

module lif_neuron_array #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned THRESHOLD   = 100,
    parameter int unsigned LEAK_MODE   = 0,
    parameter int unsigned LEAK        = 2,
    parameter int unsigned REF_PERIOD  = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cur_valid,
    output logic                               cur_ready,
    input  logic [WIDTH-1:0]                   cur_data,
    output logic                               spike_valid,
    input  logic                               spike_ready,
    output logic [$clog2(NUM_NEURONS)-1:0]     spike_id,
    output logic                               frame_done
`ifdef LIF_STATS_EN
    ,
    output logic [$clog2(NUM_NEURONS+1)-1:0]   spike_count
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_NEURONS);
    // A zero refractory period still needs a 1-bit counter that never loads.
    localparam int unsigned RefW = (REF_PERIOD > 0) ? $clog2(REF_PERIOD + 1) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURONS - 1);
    localparam logic [RefW-1:0] RefLoad = RefW'(REF_PERIOD);

    // Neuron state
    logic [WIDTH-1:0] mem_q [NUM_NEURONS];
    logic [RefW-1:0]  ref_q [NUM_NEURONS];
    logic [IdxW-1:0]  idx_q;

    // Output registers
    logic             spike_valid_q;
    logic [IdxW-1:0]  spike_id_q;
    logic             frame_done_q;

    // Shared datapath
    logic [WIDTH-1:0] v_cur;
    logic [RefW-1:0]  ref_cur;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] s_val;
    logic [WIDTH-1:0] l_val;
    logic [WIDTH-1:0] mem_nxt;
    logic [RefW-1:0]  ref_nxt;
    logic             refractory;
    logic             fire;
    logic             handshake;
    logic             last;

    // Stalls only while a spike is held and not being taken this cycle.
    assign cur_ready = !(spike_valid_q && !spike_ready);
    assign handshake = cur_valid && cur_ready;
    assign last      = (idx_q == LastIdx);

    always_comb begin
        v_cur   = mem_q[idx_q];
        ref_cur = ref_q[idx_q];

        // Integrate one bit wider, then saturate at all-ones.
        sum_w = {1'b0, v_cur} + {1'b0, cur_data};
        s_val = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];

        if (LEAK_MODE == 0) begin
            l_val = (32'(s_val) > LEAK) ? (s_val - WIDTH'(LEAK)) : '0;
        end else begin
            l_val = s_val - (s_val >> LEAK);
        end

        refractory = (ref_cur != '0);
        fire       = !refractory && (32'(l_val) >= THRESHOLD);

        mem_nxt = l_val;
        ref_nxt = ref_cur;
        if (refractory) begin
            // Input is discarded while refractory; membrane stays clamped at 0.
            mem_nxt = '0;
            ref_nxt = ref_cur - RefW'(1);
        end else if (fire) begin
            mem_nxt = '0;
            ref_nxt = RefLoad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                mem_q[i] <= '0;
                ref_q[i] <= '0;
            end
            idx_q <= '0;
        end else if (handshake) begin
            mem_q[idx_q] <= mem_nxt;
            ref_q[idx_q] <= ref_nxt;
            idx_q        <= last ? '0 : idx_q + IdxW'(1);
        end
    end

    // A new spike always wins; a held spike is only dropped once accepted.
    // A new spike can only occur when cur_ready is high, i.e. the old one is
    // either absent or being taken this very cycle, so nothing is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= handshake && last;
            if (handshake && fire) begin
                spike_valid_q <= 1'b1;
                spike_id_q    <= idx_q;
            end else if (spike_ready) begin
                spike_valid_q <= 1'b0;
            end
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_id    = spike_id_q;
    assign frame_done  = frame_done_q;

`ifdef LIF_STATS_EN
    localparam int unsigned CntW = $clog2(NUM_NEURONS + 1);

    logic [CntW-1:0] frame_cnt_q;
    logic [CntW-1:0] spike_count_q;

    // The last neuron's own spike is folded into the published total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            spike_count_q <= '0;
        end else if (handshake) begin
            if (last) begin
                spike_count_q <= frame_cnt_q + CntW'(fire);
                frame_cnt_q   <= '0;
            end else if (fire) begin
                frame_cnt_q <= frame_cnt_q + CntW'(1);
            end
        end
    end

    assign spike_count = spike_count_q;
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed testbench for lif_neuron_array. A mode-0 (subtractive leak) and a
// mode-1 (shift leak) instance share the same stimulus.

module tb_lif_neuron_array;

    logic       clk;
    logic       rst_n;
    logic       cur_valid;
    logic [7:0] cur_data;
    logic       spike_ready;

    logic       cur_ready,   cur_ready1;
    logic       spike_valid, spike_valid1;
    logic [1:0] spike_id,    spike_id1;
    logic       frame_done,  frame_done1;
`ifdef LIF_STATS_EN
    logic [2:0] spike_count, spike_count1;
`endif

    int errors;
    int checks;

    // Outputs captured just after the edge that consumed the last beat
    logic       sv0, fd0, sv1, fd1;
    logic [1:0] sid0, sid1;

    lif_neuron_array #(
        .NUM_NEURONS(4), .WIDTH(8), .THRESHOLD(100),
        .LEAK_MODE(0), .LEAK(2), .REF_PERIOD(3)
    ) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cur_valid   (cur_valid),
        .cur_ready   (cur_ready),
        .cur_data    (cur_data),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_id    (spike_id),
        .frame_done  (frame_done)
`ifdef LIF_STATS_EN
        ,
        .spike_count (spike_count)
`endif
    );

    lif_neuron_array #(
        .NUM_NEURONS(4), .WIDTH(8), .THRESHOLD(100),
        .LEAK_MODE(1), .LEAK(2), .REF_PERIOD(3)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cur_valid   (cur_valid),
        .cur_ready   (cur_ready1),
        .cur_data    (cur_data),
        .spike_valid (spike_valid1),
        .spike_ready (spike_ready),
        .spike_id    (spike_id1),
        .frame_done  (frame_done1)
`ifdef LIF_STATS_EN
        ,
        .spike_count (spike_count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cur_valid = 1'b0;
        cur_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one beat, wait (bounded) for acceptance, capture outputs after it.
    task automatic send_beat(input logic [7:0] d);
        int n;
        @(negedge clk);
        cur_valid = 1'b1;
        cur_data  = d;
        n = 0;
        while (!cur_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: cur_ready=%0b want 1 within 50 cycles", cur_ready);
        end
        @(posedge clk);
        #1;
        sv0  = spike_valid;
        sid0 = spike_id;
        fd0  = frame_done;
        sv1  = spike_valid1;
        sid1 = spike_id1;
        fd1  = frame_done1;
        cur_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cur_valid = 1'b1;
        cur_data  = 8'd255;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cur_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cur_ready: got %0b want 1", cur_ready);
        end
        checks++;
        if (spike_valid !== 1'b0) begin
            errors++; $display("FAIL reset_spike_valid: got %0b want 0", spike_valid);
        end
        checks++;
        if (spike_id !== 2'd0) begin
            errors++; $display("FAIL reset_spike_id: got %0d want 0", spike_id);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done);
        end
        checks++;
        if (u_dut0.mem_q[0] !== 8'd0 || u_dut0.idx_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: mem0=%0d idx=%0d want 0 0", u_dut0.mem_q[0], u_dut0.idx_q);
        end
`ifdef LIF_STATS_EN
        checks++;
        if (spike_count !== 3'd0) begin
            errors++; $display("FAIL reset_spike_count: got %0d want 0", spike_count);
        end
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        cur_valid = 1'b0;
        // First beat after release must hit neuron 0: 150-2=148 spikes.
        send_beat(8'd150);
        checks++;
        if (sv0 !== 1'b1 || sid0 !== 2'd0) begin
            errors++; $display("FAIL reset_first_idx: valid=%0b id=%0d want 1 0", sv0, sid0);
        end
        checks++;
        if (fd0 !== 1'b0) begin
            errors++; $display("FAIL reset_early_frame_done: got %0b want 0", fd0);
        end
        send_beat(8'd0);
        send_beat(8'd0);
        send_beat(8'd0);
        checks++;
        if (fd0 !== 1'b1) begin
            errors++; $display("FAIL reset_frame_done_last: got %0b want 1", fd0);
        end
    endtask

    task automatic test_integration();
        logic [7:0] exp_mem;
        do_reset();
        for (int f = 1; f <= 6; f++) begin
            send_beat(8'd20);
            checks++;
            if (sv0 !== (f == 6)) begin
                errors++; $display("FAIL integ_spike_f%0d: got %0b want %0b", f, sv0, (f == 6));
            end
            if (f == 6) begin
                checks++;
                if (sid0 !== 2'd0) begin
                    errors++; $display("FAIL integ_spike_id: got %0d want 0", sid0);
                end
            end
            send_beat(8'd0);
            send_beat(8'd0);
            send_beat(8'd0);
            exp_mem = (f < 6) ? 8'(18 * f) : 8'd0;
            checks++;
            if (u_dut0.mem_q[0] !== exp_mem) begin
                errors++;
                $display("FAIL integ_mem0_f%0d: got %0d want %0d", f, u_dut0.mem_q[0], exp_mem);
            end
            checks++;
            if (u_dut0.mem_q[1] !== 8'd0 || u_dut0.mem_q[3] !== 8'd0) begin
                errors++;
                $display("FAIL integ_other_mem_f%0d: m1=%0d m3=%0d want 0 0", f,
                         u_dut0.mem_q[1], u_dut0.mem_q[3]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        send_beat(8'd0);
        send_beat(8'd92);
        send_beat(8'd0);
        send_beat(8'd0);
        checks++;
        if (u_dut0.mem_q[1] !== 8'd90) begin
            errors++; $display("FAIL sat_mem1_setup: got %0d want 90", u_dut0.mem_q[1]);
        end
        send_beat(8'd0);
        send_beat(8'd200);
        checks++;
        if (sv0 !== 1'b1 || sid0 !== 2'd1) begin
            errors++; $display("FAIL sat_spike: valid=%0b id=%0d want 1 1", sv0, sid0);
        end
        checks++;
        if (u_dut0.mem_q[1] !== 8'd0 || u_dut0.mem_q[0] !== 8'd0) begin
            errors++;
            $display("FAIL sat_mem: m1=%0d m0=%0d want 0 0", u_dut0.mem_q[1], u_dut0.mem_q[0]);
        end
    endtask

    task automatic test_refractory();
        logic       exp_spike;
        logic [1:0] exp_ref;
        do_reset();
        for (int f = 1; f <= 9; f++) begin
            exp_spike = ((f - 1) % 4 == 0);
            exp_ref   = exp_spike ? 2'd3 : 2'(3 - ((f - 1) % 4));
            send_beat(8'd0);
            send_beat(8'd0);
            send_beat(8'd255);
            checks++;
            if (sv0 !== exp_spike || (exp_spike && sid0 !== 2'd2)) begin
                errors++;
                $display("FAIL refr_spike_f%0d: valid=%0b id=%0d want %0b 2", f, sv0, sid0,
                         exp_spike);
            end
            checks++;
            if (u_dut0.ref_q[2] !== exp_ref || u_dut0.mem_q[2] !== 8'd0) begin
                errors++;
                $display("FAIL refr_state_f%0d: ref=%0d mem=%0d want %0d 0", f,
                         u_dut0.ref_q[2], u_dut0.mem_q[2], exp_ref);
            end
            send_beat(8'd0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        spike_ready = 1'b0;
        send_beat(8'd150);
        @(negedge clk);
        cur_valid = 1'b1;
        cur_data  = 8'd50;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cur_ready !== 1'b0 || spike_valid !== 1'b1 || spike_id !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold_c%0d: ready=%0b valid=%0b id=%0d want 0 1 0", i,
                         cur_ready, spike_valid, spike_id);
            end
            checks++;
            if (u_dut0.idx_q !== 2'd1) begin
                errors++; $display("FAIL bp_idx_c%0d: got %0d want 1", i, u_dut0.idx_q);
            end
            @(negedge clk);
        end
        spike_ready = 1'b1;
        #1;
        checks++;
        if (cur_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %0b want 1", cur_ready);
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        checks++;
        if (spike_valid !== 1'b0 || u_dut0.mem_q[1] !== 8'd48 || u_dut0.idx_q !== 2'd2) begin
            errors++;
            $display("FAIL bp_after: valid=%0b mem1=%0d idx=%0d want 0 48 2", spike_valid,
                     u_dut0.mem_q[1], u_dut0.idx_q);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        cur_valid = 1'b1;
        cur_data  = 8'd150;
        @(posedge clk);
        #1;
        checks++;
        if (spike_valid !== 1'b1 || spike_id !== 2'd0) begin
            errors++; $display("FAIL b2b_first: valid=%0b id=%0d want 1 0", spike_valid, spike_id);
        end
        @(posedge clk);
        #1;
        cur_data = 8'd0;
        checks++;
        if (spike_valid !== 1'b1 || spike_id !== 2'd1) begin
            errors++;
            $display("FAIL b2b_replace: valid=%0b id=%0d want 1 1", spike_valid, spike_id);
        end
        @(posedge clk);
        #1;
        checks++;
        if (spike_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear: valid=%0b fd=%0b want 0 0", spike_valid, frame_done);
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++; $display("FAIL b2b_frame_done: got %0b want 1", frame_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL b2b_fd_pulse: got %0b want 0", frame_done);
        end
    endtask

    task automatic test_shift_stats();
        do_reset();
        send_beat(8'd0);
        send_beat(8'd0);
        send_beat(8'd0);
        send_beat(8'd80);
        checks++;
        if (u_dut1.mem_q[3] !== 8'd60 || sv1 !== 1'b0 || fd1 !== 1'b1) begin
            errors++;
            $display("FAIL shift_f1: mem3=%0d valid=%0b fd=%0b want 60 0 1", u_dut1.mem_q[3],
                     sv1, fd1);
        end
`ifdef LIF_STATS_EN
        checks++;
        if (spike_count1 !== 3'd0) begin
            errors++; $display("FAIL stats_f1: got %0d want 0", spike_count1);
        end
`endif
        send_beat(8'd0);
        send_beat(8'd0);
        send_beat(8'd0);
        send_beat(8'd80);
        checks++;
        if (sv1 !== 1'b1 || sid1 !== 2'd3 || fd1 !== 1'b1 || u_dut1.mem_q[3] !== 8'd0) begin
            errors++;
            $display("FAIL shift_f2: valid=%0b id=%0d fd=%0b mem3=%0d want 1 3 1 0", sv1, sid1,
                     fd1, u_dut1.mem_q[3]);
        end
`ifdef LIF_STATS_EN
        checks++;
        if (spike_count1 !== 3'd1) begin
            errors++; $display("FAIL stats_f2: got %0d want 1", spike_count1);
        end
`endif
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        cur_valid   = 1'b0;
        cur_data    = '0;
        spike_ready = 1'b1;
        sv0 = 1'b0; sid0 = '0; fd0 = 1'b0;
        sv1 = 1'b0; sid1 = '0; fd1 = 1'b0;

        test_reset();
        test_integration();
        test_saturation();
        test_refractory();
        test_backpressure();
        test_back_to_back();
        test_shift_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons sharing one update datapath, the generalised successor to the single-neuron LIF cell. Per-neuron membrane potential and refractory counter live in internal register arrays. Input currents arrive as a ready/valid stream in neuron-index order, one neuron per accepted beat. Spikes leave as a ready/valid stream of neuron IDs for the downstream router.

## Interface
- NUM_NEURONS, 4: neurons in the array, ≥2.
- WIDTH, 8: membrane and current width, unsigned.
- THRESHOLD, 100: spike when post-leak potential ≥ THRESHOLD; 1..2^WIDTH-1.
- LEAK_MODE, 0: 0 = subtractive leak, 1 = shift leak.
- LEAK, 2: amount subtracted per update (mode 0), or right-shift amount (mode 1).
- REF_PERIOD, 3: updates a neuron ignores after a spike; 0 disables refractory.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cur_valid  in  1  current beat valid.
- cur_ready  out  1  array accepts beat.
- cur_data  in  WIDTH  input current for neuron at current index.
- spike_valid  out  1  spike event pending.
- spike_ready  in  1  downstream accepts spike.
- spike_id  out  $clog2(NUM_NEURONS)  index of spiking neuron.
- frame_done  out  1  one-cycle pulse, neuron NUM_NEURONS-1 updated.
- spike_count  out  $clog2(NUM_NEURONS+1)  spikes in last frame (LIF_STATS_EN only).

## Operation
- Index counter idx starts at 0. Each handshake (cur_valid && cur_ready) updates neuron idx, then idx increments and wraps from NUM_NEURONS-1 to 0.
- cur_ready = !(spike_valid && !spike_ready). The array stalls only while a spike is held.
- Refractory neuron (ref_cnt > 0): cur_data discarded, membrane held at 0, ref_cnt decrements by 1, no spike.
- Active neuron:
  - s = min(v + cur_data, 2^WIDTH-1), computed WIDTH+1 wide then saturated.
  - Mode 0: l = (s > LEAK) ? s - LEAK : 0.
  - Mode 1: l = s - (s >> LEAK).
- If l ≥ THRESHOLD: spike. Membrane set to 0, ref_cnt set to REF_PERIOD, spike_valid set with spike_id = idx.
- Otherwise the membrane is set to l.
- ref_cnt width: $clog2(REF_PERIOD+1), minimum 1.
- spike_valid/spike_id hold stable until spike_ready. When spike_ready is high and no new spike occurs that cycle, spike_valid clears.
- A spike accepted in the same cycle that a new spike is produced is replaced by the new spike. spike_valid stays high.
- Reset mid-frame discards all state: membranes 0, ref counters 0, idx 0, pending spike dropped.

## Timing
- Reset values: cur_ready 1, spike_valid 0, spike_id 0, frame_done 0, spike_count 0.
- Latency: beat accepted at edge t → membrane update and spike_valid visible after edge t.
- frame_done asserts in the same cycle, for one cycle.
- Throughput: one neuron per cycle with no backpressure. A full frame takes NUM_NEURONS accepted beats.
- cur_ready is combinational from registered spike_valid and the spike_ready input only. It never depends on cur_valid.

## Configuration
- LIF_STATS_EN defined:
  - An internal counter increments on each spike event in the frame.
  - At frame_done, spike_count loads the frame total (including a spike on neuron NUM_NEURONS-1) and holds it until the next frame_done.
  - The internal counter clears for the next frame.
- LIF_STATS_EN undefined: the counter and the spike_count port are absent. All other behaviour is identical.

## Test plan
Defaults NUM_NEURONS=4, WIDTH=8, THRESHOLD=100, LEAK_MODE=0, LEAK=2, REF_PERIOD=3, spike_ready=1 unless stated.
- Reset: hold rst_n=0 for 2 cycles with cur_valid=1 → no handshake side effects; outputs at reset values; first frame after release starts at neuron 0.
- Integration/leak: per frame, neuron 0 gets 20 and others get 0 → neuron 0 membrane 18, 36, 54, 72, 90; spike_id=0 in frame 6; other membranes stay 0, clamped with no underflow.
- Saturation: neuron 1 membrane 90, cur_data=200 → s saturates to 255, l=253 → spike_id=1, membrane 0, with no wrap-around to a small value.
- Refractory: neuron 2 gets 255 every frame → spikes in frames 1, 5, 9; frames 2–4 ignore input, ref_cnt goes 3→2→1→0.
- Backpressure: spike pending with spike_ready=0 for 5 cycles → cur_ready=0, spike_id stable, idx frozen, no beat lost; after release the next beat goes to the next neuron.
- Shift leak / stats: LEAK_MODE=1, LEAK=2, neuron 3 gets 80 then 80 → membrane 60, then 140-35=105 → spike; with LIF_STATS_EN, spike_count=1 after that frame_done.
